// File: rtl/wm_pkg.sv
// Shared types, command codes and per-program lookup tables for the
// washing-machine program sequencer.
package wm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WASH  = 3'd2,
        ST_RINSE = 3'd3,
        ST_SPIN  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } state_t;

    localparam logic [2:0] CMD_STOP  = 3'd0;
    localparam logic [2:0] CMD_FILL  = 3'd1;
    localparam logic [2:0] CMD_WASH  = 3'd2;
    localparam logic [2:0] CMD_RINSE = 3'd3;
    localparam logic [2:0] CMD_SPIN  = 3'd4;

    localparam logic [7:0] ARG_FILL  = 8'd0;
    localparam logic [7:0] ARG_WASH  = 8'd60;
    localparam logic [7:0] ARG_RINSE = 8'd40;
    localparam logic [7:0] ARG_STOP  = 8'd0;

    // Program 3 is not a distinct program; it falls through to normal.
    function automatic logic [7:0] wash_ticks(input logic [1:0] prog);
        case (prog)
            2'd0:    return 8'd10;
            2'd2:    return 8'd30;
            default: return 8'd20;
        endcase
    endfunction

    function automatic logic [7:0] rinse_ticks(input logic [1:0] prog);
        case (prog)
            2'd0:    return 8'd5;
            2'd2:    return 8'd15;
            default: return 8'd10;
        endcase
    endfunction

    function automatic logic [7:0] spin_ticks(input logic [1:0] prog);
        case (prog)
            2'd0:    return 8'd5;
            2'd2:    return 8'd12;
            default: return 8'd8;
        endcase
    endfunction

    function automatic logic [7:0] spin_speed(input logic [1:0] prog);
        case (prog)
            2'd0:    return 8'd120;
            2'd2:    return 8'd200;
            default: return 8'd160;
        endcase
    endfunction

    function automatic logic [2:0] cmd_code(input state_t st);
        case (st)
            ST_FILL:  return CMD_FILL;
            ST_WASH:  return CMD_WASH;
            ST_RINSE: return CMD_RINSE;
            ST_SPIN:  return CMD_SPIN;
            default:  return CMD_STOP;
        endcase
    endfunction

    function automatic logic [7:0] cmd_argument(input state_t st, input logic [1:0] prog);
        case (st)
            ST_FILL:  return ARG_FILL;
            ST_WASH:  return ARG_WASH;
            ST_RINSE: return ARG_RINSE;
            ST_SPIN:  return spin_speed(prog);
            default:  return ARG_STOP;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating 8-bit phase tick counter. `expired` flags the cycle whose
// enabled tick is the limit-th one, so the owner can leave on that edge.
module phase_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       en,
    input  logic [7:0] limit,
    output logic       expired
);

    logic [7:0] count_r;

    assign expired = en && (({1'b0, count_r} + 9'd1) >= {1'b0, limit});

    // Tick counter: cleared on phase entry, saturates at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 8'd0;
        end else if (clear) begin
            count_r <= 8'd0;
        end else if (en && (count_r < limit)) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/wash_sequencer.sv
// Washing-machine program sequencer: FSM, program latch and the
// valid/ready command register feeding the machine-control stage.
module wash_sequencer
    import wm_pkg::*;
#(
    parameter int FILL_TIMEOUT = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic [1:0] prog,
    input  logic       door_closed,
    input  logic       water_full,
    input  logic       tick,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [2:0] cmd,
    output logic [7:0] cmd_arg,
    output logic       door_lock,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [2:0] phase
);

    localparam logic [7:0] FILL_LIMIT = 8'(FILL_TIMEOUT);

    state_t     state_r;
    state_t     next_state_s;
    logic [1:0] prog_r;
    logic       accepted_r;
    logic       cmd_valid_r;
    logic [2:0] cmd_r;
    logic [7:0] cmd_arg_r;
    logic       busy_r;
    logic       done_r;
    logic       fault_r;
    logic       handshake_s;
    logic       tick_en_s;
    logic       entry_s;
    logic       expired_s;
    logic [7:0] limit_s;

    assign handshake_s = cmd_valid_r && cmd_ready;
    assign tick_en_s   = tick && !pause && accepted_r;
    assign entry_s     = (next_state_s != state_r);

    assign phase     = state_r;
    assign cmd_valid = cmd_valid_r;
    assign cmd       = cmd_r;
    assign cmd_arg   = cmd_arg_r;
    assign busy      = busy_r;
    assign door_lock = busy_r;
    assign done      = done_r;
    assign fault     = fault_r;

    // Duration of the current phase, from the latched program.
    always_comb begin
        limit_s = 8'd0;
        case (state_r)
            ST_FILL:  limit_s = FILL_LIMIT;
            ST_WASH:  limit_s = wash_ticks(prog_r);
            ST_RINSE: limit_s = rinse_ticks(prog_r);
            ST_SPIN:  limit_s = spin_ticks(prog_r);
            default:  limit_s = 8'd0;
        endcase
    end

    phase_timer u_phase_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (entry_s),
        .en      (tick_en_s),
        .limit   (limit_s),
        .expired (expired_s)
    );

    // Next-state logic; door fault outranks every other exit.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && door_closed) next_state_s = ST_FILL;
                else                      next_state_s = ST_IDLE;
            end
            ST_FILL: begin
                if (!door_closed)                   next_state_s = ST_ERROR;
                else if (accepted_r && water_full)  next_state_s = ST_WASH;
                else if (expired_s)                 next_state_s = ST_ERROR;
                else                                next_state_s = ST_FILL;
            end
            ST_WASH: begin
                if (!door_closed)   next_state_s = ST_ERROR;
                else if (expired_s) next_state_s = ST_RINSE;
                else                next_state_s = ST_WASH;
            end
            ST_RINSE: begin
                if (!door_closed)   next_state_s = ST_ERROR;
                else if (expired_s) next_state_s = ST_SPIN;
                else                next_state_s = ST_RINSE;
            end
            ST_SPIN: begin
                if (!door_closed)   next_state_s = ST_ERROR;
                else if (expired_s) next_state_s = ST_DONE;
                else                next_state_s = ST_SPIN;
            end
            ST_DONE: begin
                if (handshake_s) next_state_s = ST_IDLE;
                else             next_state_s = ST_DONE;
            end
            ST_ERROR: next_state_s = ST_ERROR;
            default:  next_state_s = ST_ERROR;
        endcase
    end

    // State, program latch, command register and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            prog_r      <= 2'd0;
            accepted_r  <= 1'b0;
            cmd_valid_r <= 1'b0;
            cmd_r       <= CMD_STOP;
            cmd_arg_r   <= ARG_STOP;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            fault_r     <= 1'b0;
        end else begin
            state_r <= next_state_s;
            done_r  <= (state_r == ST_DONE) && (next_state_s == ST_IDLE);
            busy_r  <= (next_state_s != ST_IDLE) && (next_state_s != ST_ERROR);
            fault_r <= fault_r || (next_state_s == ST_ERROR);

            if ((state_r == ST_IDLE) && entry_s) prog_r <= prog;
            else                                 prog_r <= prog_r;

            // A new phase replaces any outstanding command with its own.
            if (entry_s) begin
                accepted_r  <= 1'b0;
                cmd_valid_r <= (next_state_s != ST_IDLE);
                if (next_state_s != ST_IDLE) begin
                    cmd_r     <= cmd_code(next_state_s);
                    cmd_arg_r <= cmd_argument(next_state_s, prog_r);
                end else begin
                    cmd_r     <= cmd_r;
                    cmd_arg_r <= cmd_arg_r;
                end
            end else if (handshake_s) begin
                accepted_r  <= 1'b1;
                cmd_valid_r <= 1'b0;
                cmd_r       <= cmd_r;
                cmd_arg_r   <= cmd_arg_r;
            end else begin
                accepted_r  <= accepted_r;
                cmd_valid_r <= cmd_valid_r;
                cmd_r       <= cmd_r;
                cmd_arg_r   <= cmd_arg_r;
            end
        end
    end

endmodule

// File: tb/tb_wash_sequencer.sv
// Scoreboard bench for wash_sequencer: expected commands are queued by the
// stimulus and checked by a monitor on every accepted handshake.
module tb_wash_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, pause, door_closed, water_full, tick, cmd_ready;
    logic [1:0] prog;
    logic       cmd_valid, door_lock, busy, done, fault;
    logic [2:0] cmd, phase;
    logic [7:0] cmd_arg;

    int checks   = 0;
    int failures = 0;

    logic [10:0] exp_q[$];
    int exp_len[8];
    int exp_raw[8];
    int cur_phase, cnt, raw, done_cnt, prev_phase;
    bit acc, prev_hold;
    logic [10:0] prev_cmd;
    int tcnt = 0;

    always #5 clk = ~clk;

    wash_sequencer #(.FILL_TIMEOUT(30)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .prog(prog),
        .door_closed(door_closed), .water_full(water_full), .tick(tick),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd), .cmd_arg(cmd_arg),
        .door_lock(door_lock), .busy(busy), .done(done), .fault(fault), .phase(phase)
    );

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Time base: one-cycle tick every fourth clock.
    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tcnt++;
            tick = (tcnt % 4 == 0);
        end
    end

    // Monitor: command scoreboard, hold stability and per-phase tick counts.
    initial begin
        logic [10:0] e;
        cur_phase = 0; cnt = 0; raw = 0; acc = 0; prev_hold = 0; done_cnt = 0; prev_phase = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cur_phase = 0; cnt = 0; raw = 0; acc = 0; prev_hold = 0;
            end else begin
                if (int'(phase) != cur_phase) begin
                    if (exp_len[cur_phase] >= 0)
                        check($sformatf("counted_ticks_phase%0d", cur_phase), cnt, exp_len[cur_phase]);
                    if (exp_raw[cur_phase] >= 0)
                        check($sformatf("raw_ticks_phase%0d", cur_phase), raw, exp_raw[cur_phase]);
                    cur_phase = int'(phase); cnt = 0; raw = 0; acc = 0;
                end
                if (prev_hold && int'(phase) == prev_phase)
                    check("held_cmd", int'({cmd_valid, cmd, cmd_arg}), int'({1'b1, prev_cmd}));
                if (tick && acc) begin
                    raw++;
                    if (!pause) cnt++;
                end
                if (done) done_cnt++;
                if (cmd_valid && cmd_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_cmd_code", int'(cmd), -1);
                    end else begin
                        e = exp_q.pop_front();
                        check("cmd_code", int'(cmd), int'(e[10:8]));
                        check("cmd_arg", int'(cmd_arg), int'(e[7:0]));
                    end
                    acc = 1;
                end
                prev_hold  = cmd_valid && !cmd_ready;
                prev_cmd   = {cmd, cmd_arg};
                prev_phase = int'(phase);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 8; i++) begin exp_len[i] = -1; exp_raw[i] = -1; end
    endtask

    task automatic set_dur(input int w, input int r, input int s);
        exp_len[2] = w; exp_len[3] = r; exp_len[4] = s;
    endtask

    task automatic push(input logic [2:0] c, input logic [7:0] a);
        exp_q.push_back({c, a});
    endtask

    task automatic wait_phase(input int target, input int maxc, input string name);
        bit hit = 0;
        for (int i = 0; i < maxc && !hit; i++) begin
            @(negedge clk);
            if (int'(phase) == target) hit = 1;
        end
        if (!hit) check(name, int'(phase), target);
    endtask

    task automatic begin_prog(input logic [1:0] p);
        prog = p;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        check("start_phase", int'(phase), 1);
        check("start_cmd_valid", int'(cmd_valid), 1);
    endtask

    task automatic fill_water();
        repeat (3) @(posedge tick);
        @(posedge clk); #1; water_full = 1'b1;
        wait_phase(2, 50, "reach_wash");
        @(posedge clk); #1; water_full = 1'b0;
    endtask

    task automatic finish_prog(input string name);
        wait_phase(0, 800, name);
        step(2);
        check("done_pulses", done_cnt, 1);
        check("idle_door_lock", int'(door_lock), 0);
        check("idle_busy", int'(busy), 0);
        check("queue_empty", exp_q.size(), 0);
        done_cnt = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1; rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        bit hit;
        rst = 1'b1; start = 1'b0; pause = 1'b0; door_closed = 1'b1;
        water_full = 1'b0; cmd_ready = 1'b1; prog = 2'd0;
        clear_exp();
        step(3);
        @(negedge clk);
        check("rst_phase", int'(phase), 0);
        check("rst_cmd_valid", int'(cmd_valid), 0);
        check("rst_cmd", int'(cmd), 0);
        check("rst_cmd_arg", int'(cmd_arg), 0);
        check("rst_busy_lock_done_fault", int'({busy, door_lock, done, fault}), 0);
        step(1); rst = 1'b0; step(1);

        // Nominal quick program
        clear_exp(); set_dur(10, 5, 5); done_cnt = 0;
        push(3'd1, 8'd0); push(3'd2, 8'd60); push(3'd3, 8'd40); push(3'd4, 8'd120); push(3'd0, 8'd0);
        begin_prog(2'd0);
        fill_water();
        check("wash_busy", int'(busy), 1);
        check("wash_door_lock", int'(door_lock), 1);
        finish_prog("quick_to_idle");

        // Backpressure on the WASH command, normal program
        clear_exp(); set_dur(20, 10, 8);
        push(3'd1, 8'd0); push(3'd2, 8'd60); push(3'd3, 8'd40); push(3'd4, 8'd160); push(3'd0, 8'd0);
        begin_prog(2'd1);
        @(posedge clk); #1; cmd_ready = 1'b0;
        fill_water();
        step(5);
        check("wash_valid_backpressure", int'(cmd_valid), 1);
        step(1); cmd_ready = 1'b1;
        finish_prog("backpressure_to_idle");

        // Pause across 4 ticks mid-RINSE, heavy program
        clear_exp(); set_dur(30, 15, 12); exp_raw[3] = 19;
        push(3'd1, 8'd0); push(3'd2, 8'd60); push(3'd3, 8'd40); push(3'd4, 8'd200); push(3'd0, 8'd0);
        begin_prog(2'd2);
        fill_water();
        hit = 0;
        for (int i = 0; i < 600 && !hit; i++) begin
            @(negedge clk); #1;
            if (int'(phase) == 3 && raw == 5) hit = 1;
        end
        if (!hit) check("reach_rinse_tick5", raw, 5);
        @(posedge clk); #2; pause = 1'b1;
        repeat (4) @(posedge tick);
        @(negedge tick); pause = 1'b0;
        finish_prog("pause_to_idle");

        // Program 3 runs normal timings; prog changes mid-run are ignored
        clear_exp(); set_dur(20, 10, 8);
        push(3'd1, 8'd0); push(3'd2, 8'd60); push(3'd3, 8'd40); push(3'd4, 8'd160); push(3'd0, 8'd0);
        begin_prog(2'd3);
        @(posedge clk); #1; prog = 2'd0;
        fill_water();
        finish_prog("prog3_to_idle");

        // FILL timeout
        clear_exp(); exp_len[1] = 30;
        push(3'd1, 8'd0); push(3'd0, 8'd0);
        begin_prog(2'd1);
        wait_phase(6, 400, "fill_timeout_error");
        check("timeout_fault", int'(fault), 1);
        check("timeout_busy", int'(busy), 0);
        check("timeout_door_lock", int'(door_lock), 0);
        step(3);
        check("timeout_stop_dropped", int'(cmd_valid), 0);
        check("timeout_holds_error", int'(phase), 6);
        check("timeout_queue_empty", exp_q.size(), 0);
        do_reset();
        @(negedge clk);
        check("fault_cleared_by_rst", int'(fault), 0);

        // Door opens during SPIN
        clear_exp(); set_dur(10, 5, -1);
        push(3'd1, 8'd0); push(3'd2, 8'd60); push(3'd3, 8'd40); push(3'd4, 8'd120); push(3'd0, 8'd0);
        begin_prog(2'd0);
        fill_water();
        wait_phase(4, 400, "reach_spin");
        step(8);
        door_closed = 1'b0;
        @(posedge clk); @(negedge clk);
        check("door_fault_phase", int'(phase), 6);
        check("door_fault_flag", int'(fault), 1);
        step(3);
        check("door_fault_queue_empty", exp_q.size(), 0);
        door_closed = 1'b1;
        do_reset();

        // Reset during WASH with an un-accepted command
        clear_exp();
        push(3'd1, 8'd0); push(3'd2, 8'd60);
        begin_prog(2'd1);
        @(posedge clk); #1; cmd_ready = 1'b0;
        fill_water();
        step(2);
        check("pre_rst_valid", int'(cmd_valid), 1);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("midrst_phase", int'(phase), 0);
        check("midrst_cmd_valid", int'(cmd_valid), 0);
        check("midrst_cmd", int'(cmd), 0);
        check("midrst_cmd_arg", int'(cmd_arg), 0);
        check("midrst_busy_lock_done_fault", int'({busy, door_lock, done, fault}), 0);
        check("midrst_pending_wash", exp_q.size(), 1);
        exp_q.delete();
        step(1); rst = 1'b0; cmd_ready = 1'b1;

        // Start with door open is ignored
        door_closed = 1'b0;
        step(1); start = 1'b1;
        step(4); start = 1'b0;
        @(negedge clk);
        check("door_open_phase", int'(phase), 0);
        check("door_open_valid", int'(cmd_valid), 0);
        check("door_open_busy", int'(busy), 0);
        door_closed = 1'b1;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wash_sequencer.md
# wash_sequencer

Program sequencer for the washing-machine datapath. It takes the user start/pause/program inputs and the door and water-level sensors, and steps through FILL, WASH, RINSE and SPIN phases timed on a slow tick. On each phase entry it issues one command (3-bit code plus 8-bit argument) over a valid/ready handshake. It sits directly upstream of the machine-control stage: `cmd` drives that stage's `ctrl`, and `cmd_arg` drives its `data_in`.

## Interface
- `FILL_TIMEOUT`, default 30: ticks allowed in FILL for `water_full` to rise before a fault.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: level; begins a program when in IDLE with the door closed.
- `pause` in 1: level; freezes the phase timer.
- `prog` in 2: program select. 0 = quick, 1 = normal, 2 = heavy, 3 = treated as normal.
- `door_closed` in 1: door sensor.
- `water_full` in 1: level sensor.
- `tick` in 1: one-cycle time-base strobe.
- `cmd_valid` out 1: command offered.
- `cmd_ready` in 1: downstream accepts the command.
- `cmd` out 3: command code.
- `cmd_arg` out 8: command argument (motor speed).
- `door_lock` out 1: door locked.
- `busy` out 1: program in progress.
- `done` out 1: one-cycle pulse at program completion.
- `fault` out 1: sticky error.
- `phase` out 3: current state encoding.

## Operation
- States and encodings: IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4, DONE=5, ERROR=6.
- Command codes: STOP=0, FILL=1, WASH=2, RINSE=3, SPIN=4. Codes 5–7 are never issued.
- Phase durations in ticks, indexed by program (quick/normal/heavy):
  - WASH: 10/20/30
  - RINSE: 5/10/15
  - SPIN: 5/8/12
- Command arguments:
  - FILL: 0
  - WASH: 60
  - RINSE: 40
  - SPIN: 120/160/200 by program
  - STOP: 0
- `prog` is latched at start. Changes to `prog` during a program are ignored.
- IDLE → FILL when `start` and `door_closed` are both high. If the door is open, `start` is ignored.
- Command issue:
  - On entry to every state except IDLE, `cmd_valid` rises with that state's code and argument.
  - `cmd`, `cmd_arg` and `cmd_valid` are held stable until the cycle in which `cmd_valid && cmd_ready`.
  - `cmd_valid` drops on the following cycle.
- The phase timer clears on state entry and counts only after the entry command has been accepted.
- FILL → WASH on `water_full` high, after acceptance.
- FILL → ERROR if `FILL_TIMEOUT` ticks elapse without `water_full`.
- WASH → RINSE → SPIN → DONE after the programmed number of ticks in each phase.
- DONE issues STOP. On STOP acceptance: `done` pulses for one cycle and the state returns to IDLE.
- ERROR issues STOP, sets `fault`, and holds until `rst`.
- From IDLE exit until return to IDLE, `busy` = 1 and `door_lock` = 1. Both are 0 in IDLE and in ERROR.
- `door_closed` low while in FILL, WASH, RINSE or SPIN → ERROR.
- `pause` high blocks tick counting and blocks timer-driven transitions. It does not block:
  - an in-flight handshake,
  - the FILL `water_full` transition,
  - the door fault.

## Timing
- Reset values: `phase` = 0, `cmd_valid` = 0, `cmd` = 0, `cmd_arg` = 0, `door_lock` = 0, `busy` = 0, `done` = 0, `fault` = 0, timer = 0.
- Start latency: `start` sampled at edge N → `phase` = FILL and `cmd_valid` = 1 after edge N.
- Phase length:
  - A phase of duration T ends on the edge that samples the T-th accepted-era tick with `pause` low.
  - The next state and its command are visible after that edge.
- A tick coincident with the handshake edge is not counted.
- Tick and `pause` in the same cycle → the tick is ignored.
- Door fault and timer expiry in the same cycle → ERROR wins.
- `water_full` and FILL timeout in the same cycle → WASH wins.
- `rst` mid-operation → all outputs return to reset values after that edge, including dropping an un-accepted `cmd_valid`.
- The timer is 8 bits and never wraps: it saturates at the duration.

## Structure
- Package `wm_pkg`:
  - state enum,
  - command-code constants,
  - duration and spin-speed lookup functions indexed by `prog`.
- Sub-module `phase_timer`:
  - ports: `clk`, `rst`, `clear`, `en` (tick & ~pause & accepted), `limit[7:0]`, `expired`;
  - 8-bit saturating counter.
- Top level holds the FSM, the program latch and the command register.

## Test plan
- Nominal quick program:
  - Stimulus: `prog` = 0, door closed, `cmd_ready` tied high, `water_full` 3 ticks after FILL.
  - Required: commands in order FILL/0, WASH/60, RINSE/40, SPIN/120, STOP/0; WASH, RINSE and SPIN last 10, 5 and 5 ticks; one `done` pulse; return to IDLE with `door_lock` = 0.
- Handshake backpressure:
  - Stimulus: `cmd_ready` held low 7 cycles on the WASH command.
  - Required: `cmd`/`cmd_arg` stable throughout; no ticks counted until acceptance; WASH still lasts exactly 20 ticks for `prog` = 1.
- Pause:
  - Stimulus: `pause` high for 4 ticks mid-RINSE, `prog` = 2.
  - Required: RINSE spans 19 tick pulses but only 15 are counted; a tick coincident with `pause` is not counted.
- Faults:
  - Stimulus A: `water_full` never rises. Required: ERROR after 30 ticks, STOP issued, `fault` = 1, `busy` = 0.
  - Stimulus B: `door_closed` drops during SPIN. Required: ERROR on the next cycle.
- Reset and guards:
  - Stimulus A: `rst` during WASH with `cmd_valid` high. Required: all outputs 0 after the edge.
  - Stimulus B: `start` with door open. Required: stays in IDLE.
  - Stimulus C: `prog` = 3. Required: normal timings.
